// File: rtl/wb_pkg.sv
// Shared Wishbone interconnect types and helpers.
package wb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUSY  = 2'd1,
      ARB_ABORT = 2'd2
   } arb_state_t;

   function automatic int unsigned sel_width(input int unsigned data_width,
                                             input int unsigned granule);
      return data_width / granule;
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Rotating priority encoder: first requester at or after ptr, wrapping.
module wb_rr_pick #(
   parameter int unsigned N = 4,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      int unsigned k;
      k     = 0;
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (32'(ptr) + i) % N;
         if (!valid && req[k]) begin
            valid  = 1'b1;
            gnt[k] = 1'b1;
            idx    = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: per-CYC ownership, owner-only ACK/ERR, watchdog abort.
module wb_rr_arbiter
   import wb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
   parameter int unsigned ADDR_WIDTH  = 16,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned GRANULE     = 8,
   parameter int unsigned TIMEOUT     = 255,
   localparam int unsigned SEL_WIDTH  = sel_width(DATA_WIDTH, GRANULE)
) (
   input  logic                              clk_i,
   input  logic                              rst_n_i,
   input  logic [NUM_MASTERS-1:0]            m_cyc_i,
   input  logic [NUM_MASTERS-1:0]            m_stb_i,
   input  logic [NUM_MASTERS-1:0]            m_we_i,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
   input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
   output logic [DATA_WIDTH-1:0]             m_dat_o,
   output logic [NUM_MASTERS-1:0]            m_ack_o,
   output logic [NUM_MASTERS-1:0]            m_err_o,
   output logic                              s_cyc_o,
   output logic                              s_stb_o,
   output logic                              s_we_o,
   output logic [ADDR_WIDTH-1:0]             s_adr_o,
   output logic [DATA_WIDTH-1:0]             s_dat_o,
   output logic [SEL_WIDTH-1:0]              s_sel_o,
   input  logic [DATA_WIDTH-1:0]             s_dat_i,
   input  logic                              s_ack_i,
   input  logic                              s_err_i,
   output logic [NUM_MASTERS-1:0]            gnt_o
);

   localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
   localparam int unsigned WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]       owner_q, owner_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [WD_W-1:0]        wd_q, wd_d;

   logic [NUM_MASTERS-1:0] pick_gnt;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_valid;

   logic                   own_cyc, own_stb, own_we;
   logic [ADDR_WIDTH-1:0]  own_adr;
   logic [DATA_WIDTH-1:0]  own_dat;
   logic [SEL_WIDTH-1:0]   own_sel;

   wb_rr_pick #(.N(NUM_MASTERS)) u_pick (
      .req   (m_cyc_i),
      .ptr   (ptr_q),
      .gnt   (pick_gnt),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   assign own_cyc = m_cyc_i[owner_q];
   assign own_stb = m_stb_i[owner_q];
   assign own_we  = m_we_i[owner_q];
   assign own_adr = m_adr_i[32'(owner_q)*ADDR_WIDTH +: ADDR_WIDTH];
   assign own_dat = m_dat_i[32'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
   assign own_sel = m_sel_i[32'(owner_q)*SEL_WIDTH +: SEL_WIDTH];

   assign gnt_o   = gnt_q;
   assign m_dat_o = s_dat_i;

   // Slave side is driven only while a master owns the bus; abort blocks the slave entirely.
   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_adr_o = '0;
      s_dat_o = '0;
      s_sel_o = '0;
      m_ack_o = '0;
      m_err_o = '0;
      if (state_q == ARB_BUSY) begin
         s_cyc_o          = own_cyc;
         s_stb_o          = own_stb;
         s_we_o           = own_we;
         s_adr_o          = own_adr;
         s_dat_o          = own_dat;
         s_sel_o          = own_sel;
         m_ack_o[owner_q] = s_ack_i & own_stb;
         m_err_o[owner_q] = s_err_i & own_stb;
      end else if (state_q == ARB_ABORT) begin
         m_err_o[owner_q] = own_stb;
      end
   end

   // Next-state: arbitrate in idle, hold while owner keeps CYC, release advances the pointer.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      wd_d    = '0;
      case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               state_d = ARB_BUSY;
               gnt_d   = pick_gnt;
               owner_d = pick_idx;
            end
         end
         ARB_BUSY, ARB_ABORT: begin
            if (!own_cyc) begin
               state_d = ARB_IDLE;
               gnt_d   = '0;
               ptr_d   = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);
            end else if ((state_q == ARB_BUSY) && (TIMEOUT != 0) &&
                         s_stb_o && !s_ack_i && !s_err_i) begin
               wd_d = (wd_q != WD_MAX) ? wd_q + WD_W'(1) : wd_q;
               if (wd_d == WD_MAX) begin
                  state_d = ARB_ABORT;
               end
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
      end
   end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: directed master transfers against a register slave, with a per-cycle model check.
module tb_wb_rr_arbiter;

   localparam int N  = 4;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SW = 4;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          cyc_m [N];
   logic          stb_m [N];
   logic          we_m  [N];
   logic [AW-1:0] adr_m [N];
   logic [DW-1:0] dat_m [N];
   logic [SW-1:0] sel_m [N];

   logic [N-1:0]    m_cyc, m_stb, m_we;
   logic [N*AW-1:0] m_adr;
   logic [N*DW-1:0] m_wdat;
   logic [N*SW-1:0] m_sel;
   logic [DW-1:0]   m_rdat;
   logic [N-1:0]    m_ack, m_err, gnt;
   logic            s_cyc, s_stb, s_we;
   logic [AW-1:0]   s_adr;
   logic [DW-1:0]   s_wdat;
   logic [SW-1:0]   s_sel;
   logic [DW-1:0]   s_rdat = '0;
   logic            s_ack = 1'b0;
   logic            s_err = 1'b0;
   bit              noack = 1'b0;

   always_comb begin
      m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_wdat = '0; m_sel = '0;
      for (int k = 0; k < N; k++) begin
         m_cyc[k]          = cyc_m[k];
         m_stb[k]          = stb_m[k];
         m_we[k]           = we_m[k];
         m_adr[k*AW +: AW] = adr_m[k];
         m_wdat[k*DW +: DW] = dat_m[k];
         m_sel[k*SW +: SW] = sel_m[k];
      end
   end

   wb_rr_arbiter #(
      .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRANULE(8), .TIMEOUT(TO)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
      .m_adr_i(m_adr), .m_dat_i(m_wdat), .m_sel_i(m_sel),
      .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err),
      .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we),
      .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel),
      .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err),
      .gnt_o(gnt)
   );

   // Register slave: 32 words, registered one-cycle ACK, ERR above 0x1F, silent when noack.
   logic [DW-1:0] mem [32];
   always @(posedge clk) begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (s_cyc && s_stb && !s_ack && !s_err && !noack) begin
         if (s_adr < 16'h0020) begin
            s_ack  <= 1'b1;
            s_rdat <= mem[s_adr[4:0]];
            if (s_we)
               for (int b = 0; b < SW; b++)
                  if (s_sel[b]) mem[s_adr[4:0]][b*8 +: 8] <= s_wdat[b*8 +: 8];
         end else begin
            s_err <= 1'b1;
         end
      end
   end

   int n_chk = 0;
   int n_pass = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endfunction

   // Reference model: owner (-1 = none), rotation start, consecutive unanswered strobes, abort flag.
   int mo = -1;
   int mptr = 0;
   int mwd = 0;
   bit mab = 1'b0;

   always @(posedge clk or negedge rst_n) begin : model
      int no, np, nw;
      bit na;
      if (!rst_n) begin
         mo <= -1; mptr <= 0; mwd <= 0; mab <= 1'b0;
      end else begin
         no = mo; np = mptr; nw = 0; na = mab;
         if (mo < 0) begin
            for (int i = 0; i < N; i++)
               if (no < 0 && cyc_m[(mptr + i) % N]) no = (mptr + i) % N;
         end else if (!cyc_m[mo]) begin
            np = (mo + 1) % N; no = -1; na = 1'b0;
         end else if (!mab && stb_m[mo] && !s_ack && !s_err) begin
            nw = mwd + 1;
            if (nw >= TO) na = 1'b1;
         end
         mo <= no; mptr <= np; mwd <= nw; mab <= na;
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0] eg, ea, ee;
      logic ecyc, estb, ewe;
      logic [AW-1:0] eadr;
      logic [DW-1:0] edat;
      logic [SW-1:0] esel;
      eg = '0; ea = '0; ee = '0; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
      eadr = '0; edat = '0; esel = '0;
      if (mo >= 0) begin
         eg[mo] = 1'b1;
         if (mab) begin
            ee[mo] = stb_m[mo];
         end else begin
            ecyc = cyc_m[mo]; estb = stb_m[mo]; ewe = we_m[mo];
            eadr = adr_m[mo]; edat = dat_m[mo]; esel = sel_m[mo];
            ea[mo] = s_ack & stb_m[mo];
            ee[mo] = s_err & stb_m[mo];
         end
      end
      chk("cyc_gnt", 64'(gnt), 64'(eg));
      chk("cyc_ack", 64'(m_ack), 64'(ea));
      chk("cyc_err", 64'(m_err), 64'(ee));
      chk("cyc_scyc", 64'(s_cyc), 64'(ecyc));
      chk("cyc_sstb", 64'(s_stb), 64'(estb));
      chk("cyc_rdat", 64'(m_rdat), 64'(s_rdat));
      if (!(mo >= 0 && mab)) begin
         chk("cyc_swe", 64'(s_we), 64'(ewe));
         chk("cyc_sadr", 64'(s_adr), 64'(eadr));
         chk("cyc_sdat", 64'(s_wdat), 64'(edat));
         chk("cyc_ssel", 64'(s_sel), 64'(esel));
      end
   end

   // Grant history: order of new owners and the cycle each owner's grant rose.
   int cyc_cnt = 0;
   int gq [$];
   int rise_t [N];
   logic [N-1:0] last_g = '0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
   always @(negedge clk) begin
      if (gnt != '0 && gnt != last_g)
         for (int k = 0; k < N; k++)
            if (gnt[k]) begin
               gq.push_back(k);
               rise_t[k] <= cyc_cnt;
            end
      last_g <= gnt;
   end

   function automatic int gq_at(input int i);
      return (i < gq.size()) ? gq[i] : 15;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic xfer(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit hold, output logic [DW-1:0] rd,
                       output logic [N-1:0] av, output logic [N-1:0] ev);
      int n;
      cyc_m[k] = 1'b1; stb_m[k] = 1'b1; we_m[k] = w;
      adr_m[k] = a; dat_m[k] = d; sel_m[k] = '1;
      n = 0;
      while (!(m_ack[k] || m_err[k]) && n < 200) begin
         tick(1);
         n++;
      end
      chk($sformatf("xfer_term_m%0d", k), 64'(m_ack[k] | m_err[k]), 64'(1));
      rd = m_rdat; av = m_ack; ev = m_err;
      tick(1);
      stb_m[k] = 1'b0; we_m[k] = 1'b0;
      if (!hold) cyc_m[k] = 1'b0;
   endtask

   logic [DW-1:0] rd0, rd1, rd2, rd3;
   logic [N-1:0]  av0, av1, av2, av3, ev0, ev1, ev2, ev3;
   int t_drop, w3, w4, w6;

   initial begin
      for (int k = 0; k < N; k++) begin
         cyc_m[k] = 1'b0; stb_m[k] = 1'b0; we_m[k] = 1'b0;
         adr_m[k] = '0; dat_m[k] = '0; sel_m[k] = '0;
      end
      for (int i = 0; i < 32; i++) mem[i] = '0;
      tick(2);
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_scyc", 64'(s_cyc), 64'(0));
      chk("rst_ack_err", 64'({m_ack, m_err}), 64'(0));
      rst_n = 1'b1;
      tick(1);

      // 1: single master write then read back
      fork
         xfer(0, 1'b1, 16'h0003, 32'hDEADBEEF, 1'b0, rd0, av0, ev0);
         begin
            chk("t1_gnt_pre", 64'(gnt), 64'(0));
            tick(1);
            chk("t1_gnt_1clk", 64'(gnt), 64'(4'b0001));
         end
      join
      chk("t1_wr_ack", 64'(av0), 64'(4'b0001));
      xfer(0, 1'b0, 16'h0003, '0, 1'b0, rd0, av0, ev0);
      chk("t1_rd_ack", 64'(av0), 64'(4'b0001));
      chk("t1_rd_data", 64'(rd0), 64'(32'hDEADBEEF));

      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(1);

      // 2: three simultaneous requesters, then M0 and M3 with pointer at 3
      gq.delete();
      fork
         xfer(0, 1'b1, 16'h0010, 32'h0000_0A00, 1'b0, rd0, av0, ev0);
         xfer(1, 1'b1, 16'h0011, 32'h0000_0A01, 1'b0, rd1, av1, ev1);
         xfer(2, 1'b1, 16'h0012, 32'h0000_0A02, 1'b0, rd2, av2, ev2);
      join
      chk("t2_ngrants", 64'(gq.size()), 64'(3));
      chk("t2_first", 64'(gq_at(0)), 64'(0));
      chk("t2_second", 64'(gq_at(1)), 64'(1));
      chk("t2_third", 64'(gq_at(2)), 64'(2));
      gq.delete();
      fork
         xfer(0, 1'b1, 16'h0013, 32'h0000_0B00, 1'b0, rd0, av0, ev0);
         xfer(3, 1'b1, 16'h0014, 32'h0000_0B03, 1'b0, rd3, av3, ev3);
      join
      chk("t2_m3_first", 64'(gq_at(0)), 64'(3));
      chk("t2_m0_next", 64'(gq_at(1)), 64'(0));
      xfer(1, 1'b0, 16'h0014, '0, 1'b0, rd1, av1, ev1);
      chk("t2_m3_data", 64'(rd1), 64'(32'h0000_0B03));

      // 3: M1 holds CYC across read and write while M0 waits
      fork
         begin
            xfer(1, 1'b0, 16'h0005, '0, 1'b1, rd1, av1, ev1);
            xfer(1, 1'b1, 16'h0005, 32'h12345678, 1'b0, rd1, av1, ev1);
            t_drop = cyc_cnt;
         end
         begin
            w3 = 0;
            while (!gnt[1] && w3 < 50) begin tick(1); w3++; end
            tick(1);
            xfer(0, 1'b0, 16'h0005, '0, 1'b0, rd0, av0, ev0);
         end
      join
      chk("t3_m0_gnt_delay", 64'(rise_t[0] - t_drop), 64'(2));
      chk("t3_m0_data", 64'(rd0), 64'(32'h12345678));
      chk("t3_m0_ack", 64'(av0), 64'(4'b0001));

      // 4: slave never answers, watchdog aborts
      noack = 1'b1;
      cyc_m[1] = 1'b1; stb_m[1] = 1'b1; we_m[1] = 1'b1; adr_m[1] = 16'h0006; sel_m[1] = '1;
      w4 = 0;
      while (!gnt[1] && w4 < 50) begin tick(1); w4++; end
      w4 = 0;
      while (!m_err[1] && w4 < 50) begin tick(1); w4++; end
      chk("t4_wd_cycles", 64'(w4), 64'(8));
      chk("t4_err", 64'(m_err), 64'(4'b0010));
      chk("t4_ack", 64'(m_ack), 64'(0));
      chk("t4_sstb", 64'(s_stb), 64'(0));
      cyc_m[1] = 1'b0; stb_m[1] = 1'b0; we_m[1] = 1'b0;
      tick(1);
      chk("t4_release", 64'(gnt), 64'(0));
      noack = 1'b0;
      tick(1);

      // 5: out-of-range address returns slave ERR
      xfer(2, 1'b0, 16'h0020, '0, 1'b0, rd2, av2, ev2);
      chk("t5_err", 64'(ev2), 64'(4'b0100));
      chk("t5_ack", 64'(av2), 64'(0));

      // 6: asynchronous reset in the middle of a stalled transfer
      noack = 1'b1;
      cyc_m[0] = 1'b1; stb_m[0] = 1'b1; adr_m[0] = 16'h0001; dat_m[0] = 32'hCAFEF00D;
      w6 = 0;
      while (!gnt[0] && w6 < 50) begin tick(1); w6++; end
      tick(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_gnt", 64'(gnt), 64'(0));
      chk("t6_s_ctl", 64'({s_cyc, s_stb, s_we}), 64'(0));
      chk("t6_s_adr", 64'(s_adr), 64'(0));
      chk("t6_s_dat", 64'(s_wdat), 64'(0));
      chk("t6_s_sel", 64'(s_sel), 64'(0));
      chk("t6_ack_err", 64'({m_ack, m_err}), 64'(0));
      cyc_m[1] = 1'b1; stb_m[1] = 1'b1;
      noack = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_m0_after_rst", 64'(gnt), 64'(4'b0001));
      for (int k = 0; k < N; k++) begin cyc_m[k] = 1'b0; stb_m[k] = 1'b0; end
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
      $fatal(1);
   end

endmodule
